// File: rtl/aes_pkg.sv
// aes_pkg: AES helpers shared by the encrypt core, the decrypt path and the loopback benches.
package aes_pkg;

   localparam int unsigned BLOCK_W  = 128;
   // Largest supported round count (AES-256); schedules are zero-extended to this width.
   localparam int unsigned MAX_NR   = 14;
   localparam int unsigned KS_MAX_W = BLOCK_W * (MAX_NR + 1);

   typedef logic [1:0] aes_enc_state_t;
   localparam aes_enc_state_t ST_IDLE  = 2'd0;
   localparam aes_enc_state_t ST_ROUND = 2'd1;
   localparam aes_enc_state_t ST_DONE  = 2'd2;

   // Round idx of a schedule whose round nr sits in the low 128 bits.
   function automatic logic [BLOCK_W-1:0] round_key(input logic [KS_MAX_W-1:0] ks,
                                                    input int unsigned         nr,
                                                    input logic [3:0]          idx);
      int unsigned lsb;
      lsb = BLOCK_W * (nr - 32'(idx));
      return ks[lsb +: BLOCK_W];
   endfunction

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // One MixColumns column; byte a0 is row 0.
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
      end
      return r;
   endfunction

   // Byte i is row i%4, column i/4; row r rotates left by r columns.
   function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      int                 src;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
         r[127-8*i -: 8] = s[127-8*src -: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box (GF(2^8) inverse followed by the affine map).
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] plain,
   output logic [7:0] subst
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] acc;
      logic [7:0] base;
      logic [7:0] expo;
      acc  = 8'h01;
      base = a;
      expo = 8'hFE;
      for (int i = 0; i < 8; i++) begin
         if (expo[i]) acc = gf_mul(acc, base);
         base = gf_mul(base, base);
      end
      return acc;
   endfunction

   logic [7:0] inv;

   assign inv   = gf_inv(plain);
   assign subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: round-iterative AES encryption, one cipher round per clock.
// Optional macro AES_ENC_KEY_LATCH_EN captures expanded_key at accept so the source may change.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int unsigned NR = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [127:0]           in_data,
   input  logic [128*(NR+1)-1:0]  expanded_key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [127:0]           out_data,
   output logic                   busy
);

   localparam int unsigned KW       = BLOCK_W * (NR + 1);
   localparam logic [3:0]  LAST_RND = 4'(NR);

   aes_enc_state_t fsm_q, fsm_d;
   logic [127:0]   state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [KW-1:0]  sched;
   logic [127:0]   rk0, rk_cur;
   logic [127:0]   sb_out, sr_out, mc_out, round_out;
   logic           accept;

   assign accept = in_valid && (fsm_q == ST_IDLE);

`ifdef AES_ENC_KEY_LATCH_EN
   logic [KW-1:0] key_q;

   // Snapshot the whole schedule on accept; rounds never look at the live input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q <= '0;
      end else if (accept) begin
         key_q <= expanded_key;
      end
   end

   assign sched = key_q;
`else
   assign sched = expanded_key;
`endif

   // Whitening key is read live: the latched copy is not loaded until the accept edge.
   assign rk0    = round_key(KS_MAX_W'(expanded_key), NR, 4'd0);
   assign rk_cur = round_key(KS_MAX_W'(sched), NR, rnd_q);

   for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
      aes_sbox u_sbox (
         .plain (state_q[127-8*i -: 8]),
         .subst (sb_out[127-8*i -: 8])
      );
   end

   assign sr_out    = shift_rows(sb_out);
   assign mc_out    = mix_columns(sr_out);
   assign round_out = ((rnd_q == LAST_RND) ? sr_out : mc_out) ^ rk_cur;

   // Next-state logic for the IDLE -> ROUND -> DONE sequence.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rnd_d   = rnd_q;
      case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = in_data ^ rk0;
               rnd_d   = 4'd1;
               fsm_d   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d = round_out;
            if (rnd_q == LAST_RND) begin
               fsm_d = ST_DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any block in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         rnd_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rnd_q   <= rnd_d;
      end
   end

   assign in_ready  = (fsm_q == ST_IDLE);
   assign busy      = (fsm_q == ST_ROUND);
   assign out_valid = (fsm_q == ST_DONE);
   // Intermediate round state is not exposed on the output.
   assign out_data  = out_valid ? state_q : '0;

endmodule
